// File: rtl/blctrl_scheduler.sv
// Frame scheduler for up to 8 BL-Ctrl ESCs sharing one I2C master.
// Each frame tick snapshots speeds/enables and issues one byte write per enabled motor.
module blctrl_scheduler #(
  parameter int unsigned FRAME_CYCLES   = 32000,
  parameter logic [6:0]  BASE_ADDR      = 7'h29,
  parameter int unsigned ADDR_STRIDE    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        master_enable,
  input  logic [7:0]  motor_enable,
  input  logic [63:0] target_speed_flat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_addr,
  output logic [7:0]  cmd_data,
  input  logic        cmd_done,
  input  logic        cmd_nack,
  output logic        cmd_abort,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  err_flags,
  output logic        overrun,
  input  logic        err_clear,
  output logic [2:0]  state_dbg
);
  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEL   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic [TMO_W-1:0] timer;
  logic [3:0]       idx, idx_nxt;
  logic [7:0]       mask;
  logic [7:0]       spd [8];
  logic             tick, load, timer_clr, overrun_set;
  logic [7:0]       err_set;
  logic [6:0]       addr_off;

  assign tick      = (frame_cnt == CNT_LAST);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign addr_off  = 7'(32'(idx[2:0]) * ADDR_STRIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (timer_clr) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      for (int i = 0; i < 8; i++) spd[i] <= '0;
    end else if (load) begin
      mask <= motor_enable;
      for (int i = 0; i < 8; i++) spd[i] <= master_enable ? target_speed_flat[8*i +: 8] : 8'h00;
    end
  end

  // A fresh error in the clearing cycle survives because the set term is OR-ed after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flags <= '0;
      overrun   <= 1'b0;
    end else begin
      err_flags <= (err_clear ? 8'h00 : err_flags) | err_set;
      overrun   <= (err_clear ? 1'b0 : overrun) | overrun_set;
    end
  end

  // Command handshake: cmd_valid is held with stable cmd_addr/cmd_data until the cycle
  // where cmd_valid & cmd_ready are both high; that cycle is the accept and valid drops next.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    load       = 1'b0;
    timer_clr  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_abort  = 1'b0;
    frame_done = 1'b0;
    cmd_addr   = 7'h00;
    cmd_data   = 8'h00;
    err_set    = 8'h00;
    case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        idx_nxt = 4'd0;
        if (motor_enable == 8'h00) begin
          frame_done = 1'b1;
          state_nxt  = tick ? S_LOAD : S_IDLE;
        end else begin
          state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        if (idx[3]) begin
          frame_done = 1'b1;
          state_nxt  = tick ? S_LOAD : S_IDLE;
        end else if (mask[idx[2:0]]) begin
          state_nxt = S_ISSUE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        cmd_addr  = BASE_ADDR + addr_off;
        cmd_data  = spd[idx[2:0]];
        if (cmd_ready) begin
          timer_clr = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmd_done) begin
          err_set[idx[2:0]] = cmd_nack;
          idx_nxt           = idx + 4'd1;
          state_nxt         = S_SEL;
        end else if (timer == TMO_LAST) begin
          cmd_abort         = 1'b1;
          err_set[idx[2:0]] = 1'b1;
          idx_nxt           = idx + 4'd1;
          state_nxt         = S_SEL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A tick landing on the frame's final cycle starts the next frame instead of overrunning.
    overrun_set = tick && busy && !frame_done;
  end
endmodule

// File: tb/tb_blctrl_scheduler.sv
// Bench for blctrl_scheduler: responding I2C master model, write log, per-scenario checks
// against a per-frame write list computed from the snapshotted mask and speeds.
`timescale 1ns/1ps
module tb_blctrl_scheduler;
  localparam int FC  = 400;
  localparam int TMO = 64;
  localparam logic [6:0] BASE = 7'h29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        master_enable;
  logic [7:0]  motor_enable;
  logic [63:0] target_speed_flat;
  logic        cmd_valid, cmd_ready, cmd_done, cmd_nack, cmd_abort;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        busy, frame_done, overrun, err_clear;
  logic [7:0]  err_flags;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  blctrl_scheduler #(
    .FRAME_CYCLES(FC), .BASE_ADDR(BASE), .ADDR_STRIDE(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .master_enable(master_enable), .motor_enable(motor_enable),
    .target_speed_flat(target_speed_flat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .cmd_abort(cmd_abort), .busy(busy), .frame_done(frame_done), .err_flags(err_flags),
    .overrun(overrun), .err_clear(err_clear), .state_dbg(state_dbg)
  );

  int checks = 0;
  int fails  = 0;
  int cyc;
  logic [14:0] acc_q[$];
  logic [14:0] exp_q[$];
  int acc_cyc[$];
  int done_cyc[$];
  int abort_cyc[$];
  int rise_cyc[$];
  int valid_cnt, stab_err;
  logic [7:0] nack_mask, hold_mask;
  int done_dly, rdy_mode;

  // Cycle index since reset release; equals the frame counter value modulo FC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Master model plus write/event log.
  initial begin : master_and_monitor
    logic pending, pnack, prev_busy, prev_stall;
    logic [14:0] prev_cmd;
    logic [6:0] off;
    int cnt;
    pending = 0; pnack = 0; prev_busy = 0; prev_stall = 0; prev_cmd = '0; cnt = 0;
    cmd_ready = 0; cmd_done = 0; cmd_nack = 0;
    forever begin
      @(negedge clk);
      cmd_done = 0;
      cmd_nack = 0;
      if (rst_n !== 1'b1) begin
        pending = 0; prev_busy = 0; prev_stall = 0; cmd_ready = 0;
        continue;
      end
      cmd_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          cmd_done = 1; cmd_nack = pnack; pending = 0;
        end
      end
      #1;
      if (cmd_valid) begin
        valid_cnt++;
        if (prev_stall && {cmd_addr, cmd_data} !== prev_cmd) stab_err++;
        if (cmd_ready) begin
          acc_q.push_back({cmd_addr, cmd_data});
          acc_cyc.push_back(cyc);
          off = cmd_addr - BASE;
          if (!hold_mask[off[2:0]]) begin
            pending = 1; cnt = done_dly; pnack = nack_mask[off[2:0]];
          end
        end
        prev_stall = !cmd_ready;
        prev_cmd   = {cmd_addr, cmd_data};
      end else begin
        prev_stall = 0;
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (cmd_abort) begin
        abort_cyc.push_back(cyc);
        pending = 0;
      end
      if (busy && !prev_busy) rise_cyc.push_back(cyc);
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation exceeded 70000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic void clear_log();
    acc_q.delete(); acc_cyc.delete(); done_cyc.delete(); abort_cyc.delete(); rise_cyc.delete();
    valid_cnt = 0; stab_err = 0;
  endfunction

  // Expected write list for one frame, straight from the snapshot rules.
  function automatic void build_exp(input logic [7:0] mask, input logic men, input logic [63:0] spd);
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      if (mask[i]) exp_q.push_back({7'(BASE + 7'(i)), men ? spd[8*i +: 8] : 8'h00});
  endfunction

  task automatic wait_frame_done(input string tag);
    int n, c;
    n = done_cyc.size();
    c = 0;
    while (done_cyc.size() == n && c < 3 * FC) begin
      @(negedge clk); #2; c++;
    end
    checks++;
    if (done_cyc.size() == n) begin
      fails++;
      $display("FAIL %s_frame_done: got none within %0d cycles, want one", tag, 3 * FC);
    end
  endtask

  // Sync to a frame boundary, clear errors, then log one whole frame while
  // scrambling speeds/enables after its snapshot.
  task automatic run_frame(input logic [7:0] mask, input logic men, input logic [63:0] spd,
                           input logic [7:0] nm, input logic [7:0] hm, input int dly, input int rm,
                           input string tag);
    int n, c;
    logic scr;
    motor_enable = mask; master_enable = men; target_speed_flat = spd;
    nack_mask = nm; hold_mask = hm; done_dly = dly; rdy_mode = rm;
    wait_frame_done({tag, "_sync"});
    clear_log();
    err_clear = 1;
    @(negedge clk); #2;
    err_clear = 0;
    n = done_cyc.size();
    c = 0;
    scr = 0;
    while (done_cyc.size() == n && c < 3 * FC) begin
      @(negedge clk); #2; c++;
      if (!scr && rise_cyc.size() > 0 && cyc > rise_cyc[0] + 2) begin
        target_speed_flat = {$urandom, $urandom};
        motor_enable = 8'($urandom);
        scr = 1;
      end
    end
    checks++;
    if (done_cyc.size() == n) begin
      fails++;
      $display("FAIL %s_frame_done: got none within %0d cycles, want one", tag, 3 * FC);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; err_clear = 0; master_enable = 1; motor_enable = 8'hFF;
    target_speed_flat = {$urandom, $urandom};
    nack_mask = 0; hold_mask = 0; done_dly = 5; rdy_mode = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({cmd_valid, cmd_abort, busy, frame_done, overrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000", {cmd_valid, cmd_abort, busy, frame_done, overrun});
    end
    checks++;
    if (cmd_addr !== 7'h00 || cmd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_cmd: got addr %h data %h want 00 00", cmd_addr, cmd_data);
    end
    checks++;
    if (err_flags !== 8'h00) begin
      fails++;
      $display("FAIL reset_err: got %h want 00", err_flags);
    end
    rst_n = 1;
    clear_log();
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || rise_cyc.size() != 0) begin
      fails++;
      $display("FAIL idle_before_tick: got busy %b rises %0d want 0 0", busy, rise_cyc.size());
    end
  endtask

  task automatic test_full();
    logic [63:0] spd;
    for (int i = 0; i < 8; i++) spd[8*i +: 8] = 8'(10 + i);
    run_frame(8'hFF, 1'b1, spd, 8'h00, 8'h00, 20, 0, "full");
    build_exp(8'hFF, 1'b1, spd);
    checks++;
    if (acc_q.size() != exp_q.size()) begin
      fails++; $display("FAIL full_count: got %0d want %0d", acc_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL full_write%0d: got %h/%h want %h/%h", i, acc_q[i][14:8], acc_q[i][7:0], exp_q[i][14:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (acc_cyc.size() > 0 && acc_cyc[0] % FC != 2) begin
      fails++; $display("FAIL full_latency: got phase %0d want 2", acc_cyc[0] % FC);
    end
    checks++;
    if (err_flags !== 8'h00 || overrun !== 1'b0) begin
      fails++; $display("FAIL full_err: got err %h ovr %b want 00 0", err_flags, overrun);
    end
    checks++;
    if (acc_cyc.size() > 0 && done_cyc.size() > 0 && done_cyc[0] <= acc_cyc[acc_cyc.size()-1]) begin
      fails++; $display("FAIL full_done_order: got done %0d want after %0d", done_cyc[0], acc_cyc[acc_cyc.size()-1]);
    end
  endtask

  task automatic test_sparse_and_empty();
    logic [63:0] spd;
    spd = {$urandom, $urandom};
    run_frame(8'b1010_0100, 1'b1, spd, 8'h00, 8'h00, 3, 0, "sparse");
    build_exp(8'b1010_0100, 1'b1, spd);
    checks++;
    if (acc_q.size() != 3) begin
      fails++; $display("FAIL sparse_count: got %0d want 3", acc_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sparse_write%0d: got %h/%h want %h/%h", i, acc_q[i][14:8], acc_q[i][7:0], exp_q[i][14:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (acc_cyc.size() > 0 && acc_cyc[0] % FC != 4) begin
      fails++; $display("FAIL sparse_latency: got phase %0d want 4", acc_cyc[0] % FC);
    end
    run_frame(8'h00, 1'b1, spd, 8'h00, 8'h00, 3, 0, "empty");
    checks++;
    if (valid_cnt != 0) begin
      fails++; $display("FAIL empty_valid: got %0d valid cycles want 0", valid_cnt);
    end
    checks++;
    if (done_cyc.size() > 0 && done_cyc[0] % FC != 0) begin
      fails++; $display("FAIL empty_done_phase: got %0d want 0", done_cyc[0] % FC);
    end
  endtask

  task automatic test_random();
    logic [7:0] mask, nm;
    logic men;
    logic [63:0] spd;
    for (int r = 0; r < 4; r++) begin
      mask = 8'($urandom); nm = 8'($urandom); men = 1'($urandom_range(0, 1));
      spd = {$urandom, $urandom};
      run_frame(mask, men, spd, nm, 8'h00, $urandom_range(1, 10), 1, "rand");
      build_exp(mask, men, spd);
      checks++;
      if (acc_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand%0d_count: got %0d want %0d", r, acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", r, i, acc_q[i][14:8], acc_q[i][7:0], exp_q[i][14:8], exp_q[i][7:0]);
        end
      end
      checks++;
      if (err_flags !== (nm & mask)) begin
        fails++; $display("FAIL rand%0d_err: got %h want %h", r, err_flags, nm & mask);
      end
      checks++;
      if (stab_err != 0 || overrun !== 1'b0) begin
        fails++; $display("FAIL rand%0d_stable: got %0d changes ovr %b want 0 0", r, stab_err, overrun);
      end
    end
  endtask

  task automatic test_failsafe();
    run_frame(8'hFF, 1'b0, {8{8'hC8}}, 8'h00, 8'h00, 4, 0, "failsafe");
    checks++;
    if (acc_q.size() != 8) begin
      fails++; $display("FAIL failsafe_count: got %0d want 8", acc_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i][7:0] !== 8'h00) begin
        fails++; $display("FAIL failsafe_data%0d: got %h want 00", i, acc_q[i][7:0]);
      end
    end
  endtask

  task automatic test_nack_timeout();
    logic [63:0] spd;
    spd = {$urandom, $urandom};
    run_frame(8'hFF, 1'b1, spd, 8'h08, 8'h20, 5, 0, "nto");
    build_exp(8'hFF, 1'b1, spd);
    checks++;
    if (err_flags !== 8'h28) begin
      fails++; $display("FAIL nto_err: got %h want 28", err_flags);
    end
    checks++;
    if (acc_q.size() != 8 || acc_q.size() == 0 || acc_q[acc_q.size()-1] !== exp_q[7]) begin
      fails++; $display("FAIL nto_continue: got %0d writes want 8 ending at addr 30", acc_q.size());
    end
    checks++;
    if (abort_cyc.size() != 1) begin
      fails++; $display("FAIL nto_abort_count: got %0d want 1", abort_cyc.size());
    end else if (acc_cyc.size() > 5) begin
      checks++;
      if (abort_cyc[0] - acc_cyc[5] != TMO) begin
        fails++; $display("FAIL nto_abort_time: got %0d want %0d", abort_cyc[0] - acc_cyc[5], TMO);
      end
    end
  endtask

  task automatic test_overrun();
    int c;
    run_frame(8'hFF, 1'b1, {$urandom, $urandom}, 8'h02, 8'h00, 60, 0, "ovr");
    checks++;
    if (overrun !== 1'b1 || err_flags !== 8'h02) begin
      fails++; $display("FAIL ovr_set: got ovr %b err %h want 1 02", overrun, err_flags);
    end
    motor_enable = 8'h00;
    c = 0;
    while (rise_cyc.size() < 2 && c < 3 * FC) begin
      @(negedge clk); #2; c++;
    end
    checks++;
    if (rise_cyc.size() < 2 || rise_cyc[1] - rise_cyc[0] != 2 * FC) begin
      fails++; $display("FAIL ovr_drop: got %0d rises gap %0d want gap %0d", rise_cyc.size(),
                        (rise_cyc.size() < 2) ? -1 : rise_cyc[1] - rise_cyc[0], 2 * FC);
    end
    err_clear = 1;
    @(negedge clk); #2;
    err_clear = 0;
    checks++;
    if (overrun !== 1'b0 || err_flags !== 8'h00) begin
      fails++; $display("FAIL ovr_clear: got ovr %b err %h want 0 00", overrun, err_flags);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [63:0] spd;
    spd = {$urandom, $urandom};
    motor_enable = 8'hFF; master_enable = 1; target_speed_flat = spd;
    nack_mask = 8'h00; hold_mask = 8'h00; done_dly = 30; rdy_mode = 2;
    c = 0;
    while (cmd_valid !== 1'b1 && c < 3 * FC) begin
      @(negedge clk); #2; c++;
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_issue: got valid %b busy %b want 0 0", cmd_valid, busy);
    end
    @(negedge clk); @(negedge clk);
    rdy_mode = 0; nack_mask = 8'h01;
    rst_n = 1;
    clear_log();
    c = 0;
    while (acc_q.size() < 3 && c < 3 * FC) begin
      @(negedge clk); #2; c++;
    end
    @(negedge clk); #2;
    checks++;
    if (err_flags !== 8'h01 || busy !== 1'b1) begin
      fails++; $display("FAIL rst_pre: got err %h busy %b want 01 1", err_flags, busy);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({cmd_valid, cmd_abort, busy, frame_done, overrun} !== 5'b0 || err_flags !== 8'h00) begin
      fails++;
      $display("FAIL rst_wait: got %b err %h want 00000 00", {cmd_valid, cmd_abort, busy, frame_done, overrun}, err_flags);
    end
    @(negedge clk); @(negedge clk);
    nack_mask = 8'h00;
    rst_n = 1;
    clear_log();
    wait_frame_done("rst_restart");
    build_exp(8'hFF, 1'b1, spd);
    checks++;
    if (rise_cyc.size() == 0 || rise_cyc[0] != FC) begin
      fails++; $display("FAIL rst_start: got %0d want %0d", (rise_cyc.size() == 0) ? -1 : rise_cyc[0], FC);
    end
    checks++;
    if (acc_q.size() != 8 || acc_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL rst_motor0: got %0d writes first %h want 8 first %h", acc_q.size(),
                        (acc_q.size() == 0) ? 15'h0 : acc_q[0], exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sparse_and_empty();
    test_random();
    test_failsafe();
    test_nack_timeout();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
